pio_led_sequencer: RTL

- Consumes the 32-bit PIO export word that the SPI-to-Avalon bridge writes into the PIO, and drives the 8 board user LEDs.
- Decodes the word into a LED mask, a PWM brightness, a pattern mode and a step rate.
- Generates blink, scan and counter patterns locally, so host firmware writes the PIO only when it wants a change.

---
 rtl/pio_led_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pio_led_sequencer.sv
// Purpose: decodes the PIO export word into mask/duty/mode/rate and drives the 8 user LEDs with PWM'd patterns.
// Latency: pio_word -> led = 1 sample cycle + wait to PWM wrap + 1 apply cycle + 1 output register cycle.
// Backpressure: none; pio_word is level-sampled and changes coalesce until the next PWM period boundary.
module pio_led_sequencer #(
    parameter int TICK_BASE      = 12000,
    parameter int PWM_DIV        = 1,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] pio_word,
    output logic [7:0]  led,
    output logic        cfg_applied
);

    typedef struct packed {
        logic [7:0] rate;
        logic [1:0] mode;
        logic [7:0] duty;
        logic [7:0] mask;
    } cfg_t;

    typedef enum logic {S_UP, S_DOWN} dir_e;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_SCAN   = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    localparam int         PSC_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    // Wide enough for the slowest rate: 256 * TICK_BASE clocks per tick.
    localparam int         TICK_W  = $clog2(256 * TICK_BASE);
    localparam logic [7:0] LED_INV = LED_ACTIVE_LOW ? 8'hFF : 8'h00;

    cfg_t              word_fields;
    cfg_t              smp;
    cfg_t              cfg;
    logic [PSC_W-1:0]  psc;
    logic [7:0]        pcnt;
    logic [TICK_W-1:0] tcnt;
    logic [TICK_W-1:0] tick_lim;
    logic [7:0]        cnt;
    logic              bph;
    dir_e              dir_q, dir_d;
    logic [2:0]        pos_q, pos_d;
    logic [7:0]        pat;
    logic              psc_last;
    logic              wrap;
    logic              pend;
    logic              apply;
    logic              tick;
    logic              pwm_on;
    logic              unused_bits;

    assign word_fields = {pio_word[27:20], pio_word[17:16], pio_word[15:8], pio_word[7:0]};
    assign unused_bits = &{1'b0, pio_word[31:28], pio_word[19:18]};

    assign psc_last = (psc == PSC_W'(PWM_DIV - 1));
    assign wrap     = psc_last && (pcnt == 8'd254);
    assign pend     = (smp != cfg);
    // Config only changes on a period boundary so a brightness period is never cut short.
    assign apply    = wrap && pend;
    assign pwm_on   = (pcnt < cfg.duty);
    assign tick_lim = TICK_W'({1'b0, cfg.rate} + 9'd1) * TICK_W'(TICK_BASE) - TICK_W'(1);
    assign tick     = (tcnt == tick_lim);

    // Sample the PIO word every cycle; promote it to the active config on the PWM wrap.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            smp         <= '0;
            cfg         <= '0;
            cfg_applied <= 1'b0;
        end else begin
            smp         <= word_fields;
            cfg_applied <= apply;
            if (apply) begin
                cfg <= smp;
            end
        end
    end

    // PWM prescaler and 255-step period counter (0..254).
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            psc  <= '0;
            pcnt <= 8'd0;
        end else if (psc_last) begin
            psc  <= '0;
            pcnt <= (pcnt == 8'd254) ? 8'd0 : pcnt + 8'd1;
        end else begin
            psc  <= psc + PSC_W'(1);
        end
    end

    // Rate tick plus blink phase and counter pattern; apply restarts everything and drops a coincident tick.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tcnt <= '0;
            cnt  <= 8'd0;
            bph  <= 1'b1;
        end else if (apply) begin
            tcnt <= '0;
            cnt  <= 8'd0;
            bph  <= 1'b1;
        end else if (tick) begin
            tcnt <= '0;
            if (cfg.mode == MODE_COUNT) begin
                cnt <= cnt + 8'd1;
            end
            if (cfg.mode == MODE_BLINK) begin
                bph <= ~bph;
            end
        end else begin
            tcnt <= tcnt + TICK_W'(1);
        end
    end

    // Scan FSM state register; apply forces the sweep back to position 0 going up.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            dir_q <= S_UP;
            pos_q <= 3'd0;
        end else if (apply) begin
            dir_q <= S_UP;
            pos_q <= 3'd0;
        end else begin
            dir_q <= dir_d;
            pos_q <= pos_d;
        end
    end

    // Scan next state: bounce between 0 and 7 without repeating the endpoints.
    always_comb begin
        dir_d = dir_q;
        pos_d = pos_q;
        if (tick && (cfg.mode == MODE_SCAN)) begin
            case (dir_q)
                S_UP: begin
                    if (pos_q == 3'd7) begin
                        dir_d = S_DOWN;
                        pos_d = 3'd6;
                    end else begin
                        pos_d = pos_q + 3'd1;
                    end
                end
                S_DOWN: begin
                    if (pos_q == 3'd0) begin
                        dir_d = S_UP;
                        pos_d = 3'd1;
                    end else begin
                        pos_d = pos_q - 3'd1;
                    end
                end
                default: begin
                    dir_d = S_UP;
                    pos_d = 3'd0;
                end
            endcase
        end
    end

    // Pattern selection by mode.
    always_comb begin
        pat = 8'h00;
        case (cfg.mode)
            MODE_STATIC: pat = cfg.mask;
            MODE_BLINK:  pat = bph ? cfg.mask : 8'h00;
            MODE_SCAN:   pat = (8'd1 << pos_q) & cfg.mask;
            MODE_COUNT:  pat = cnt & cfg.mask;
            default:     pat = 8'h00;
        endcase
    end

    // Registered LED drive, gated by PWM and optionally inverted.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            led <= LED_INV;
        end else begin
            led <= (pat & {8{pwm_on}}) ^ LED_INV;
        end
    end

endmodule
